// File: rtl/mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier, R = 2^32: R_out = A*B*2^-32 mod Prime.
// Optional input reduction (one conditional subtract of Prime) under MONT_MULT_IN_REDUCE_EN.
module mont_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_sig,
  input  logic [31:0] A_i,
  input  logic [31:0] B_i,
  input  logic [31:0] Prime,
  output logic [31:0] R_out,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] CALC  = 2'b01;
  localparam logic [1:0] FINAL = 2'b10;
  localparam logic [1:0] OUT   = 2'b11;

  logic [1:0]  state;
  logic [31:0] A_r;
  logic [31:0] B_r;
  logic [33:0] S;
  logic [4:0]  counter;

  logic [31:0] a_load;
  logic [31:0] b_load;
  logic [33:0] t_add;
  logic [33:0] t_red;
  logic        s_ge_p;
  logic [31:0] s_minus_p;

`ifdef MONT_MULT_IN_REDUCE_EN
  always_comb begin
    a_load = (A_i >= Prime) ? (A_i - Prime) : A_i;
    b_load = (B_i >= Prime) ? (B_i - Prime) : B_i;
  end
`else
  always_comb begin
    a_load = A_i;
    b_load = B_i;
  end
`endif

  // One Montgomery iteration: add a_i*B, make even by adding Prime, halve.
  always_comb begin
    t_add = S + (A_r[counter] ? {2'b00, B_r} : '0);
    t_red = t_add + (t_add[0] ? {2'b00, Prime} : '0);
  end

  // S < 2*Prime here, so the difference fits in 32 bits when S >= Prime.
  always_comb begin
    s_ge_p    = (S >= {2'b00, Prime});
    s_minus_p = S[31:0] - Prime;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      A_r     <= '0;
      B_r     <= '0;
      S       <= '0;
      counter <= '0;
      R_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_sig) begin
            A_r     <= a_load;
            B_r     <= b_load;
            S       <= '0;
            counter <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          S       <= t_red >> 1;
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          R_out <= s_ge_p ? s_minus_p : S[31:0];
          state <= OUT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign done = (state == OUT);

endmodule

// File: tb/tb_mont_mult.sv
// Scoreboard bench for mont_mult: driver pushes expected results, monitor checks them on done.
// Build with MONT_MULT_IN_REDUCE_EN to also exercise the input-reduction case.
module tb_mont_mult;

  logic        clk;
  logic        reset;
  logic        in_sig;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic [31:0] Prime;
  logic [31:0] R_out;
  logic        done;

  typedef struct {
    logic [31:0] r;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   n_ops    = 0;

  mont_mult dut (
    .clk   (clk),
    .reset (reset),
    .in_sig(in_sig),
    .A_i   (A_i),
    .B_i   (B_i),
    .Prime (Prime),
    .R_out (R_out),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: done must appear in the 34th cycle counting the accept cycle,
  // i.e. observed after the 33rd edge following the accept edge.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (R_out !== e.r) begin
          bad++;
          $display("FAIL result: got R_out=%h, expected %h", R_out, e.r);
        end
        total++;
        if (cyc != e.acc + 33) begin
          bad++;
          $display("FAIL latency: got done at edge %0d, expected edge %0d", cyc, e.acc + 33);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Pulse in_sig for one cycle; optionally record the expected result.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] r, input bit expect_it);
    exp_t e;
    @(negedge clk);
    A_i    = a;
    B_i    = b;
    Prime  = p;
    in_sig = 1'b1;
    e.r    = r;
    e.acc  = cyc + 1;
    if (expect_it) begin
      sb.push_back(e);
      n_ops++;
    end
    @(negedge clk);
    in_sig = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int snap;
    bit seen;
    snap = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (done_cnt != snap) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in 60 cycles, expected done", name);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] r);
    start(a, b, p, r, 1'b1);
    wait_done(name);
  endtask

  initial begin
    reset  = 1'b1;
    in_sig = 1'b0;
    A_i    = '0;
    B_i    = '0;
    Prime  = 32'd7;
    repeat (3) @(negedge clk);
    check("reset_r_out", R_out, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op("p7_3x5", 32'd3, 32'd5, 32'd7, 32'd2);
    run_op("p7_4x4", 32'd4, 32'd4, 32'd7, 32'd4);
    run_op("p7_0x6", 32'd0, 32'd6, 32'd7, 32'd0);
    run_op("p_big", 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'hCCCCCCC9);

    repeat (5) @(negedge clk);
    check("hold_r_out", R_out, 32'hCCCCCCC9);
    check("hold_done", {31'd0, done}, 32'd0);

    // Second in_sig pulse during CALC must be ignored.
    start(32'd3, 32'd5, 32'd7, 32'd2, 1'b1);
    repeat (5) @(negedge clk);
    A_i    = 32'd1;
    in_sig = 1'b1;
    @(negedge clk);
    in_sig = 1'b0;
    wait_done("ignore_in_sig");
    repeat (40) @(negedge clk);

    // Reset 10 cycles into CALC aborts without a done pulse.
    start(32'd3, 32'd5, 32'd7, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_r_out", R_out, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run_op("after_abort", 32'd3, 32'd5, 32'd7, 32'd2);

`ifdef MONT_MULT_IN_REDUCE_EN
    run_op("in_reduce", 32'd10, 32'd12, 32'd7, 32'd2);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    check("done_count", done_cnt, n_ops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
